// File: rtl/clkdist_seq_ctrl.sv
// clkdist_seq_ctrl
// Power-up / power-down sequencer for a bank of clock-distribution buffers.
// A reference bias is enabled first and given time to settle. The channels
// are then switched on one at a time in a fixed order, with a fixed spacing
// between steps. Power-down switches them off in reverse order and drops the
// bias last. A request that reverses direction mid-ramp turns the ramp around
// from the current position and does not restart it.
//
// Ports
//   clkin       sole clock, rising edge
//   rstb        asynchronous active-low reset
//   pdb         power-down-bar request, asynchronous to clkin (synchronized here)
//   therm_mask  per-thermometer-channel allow (1 = may be enabled)
//   bin_mask    per-binary-channel allow
//   atb_ena     analog test bus selection code
//   bias_en     reference bias path enable
//   en_therm    thermometer channel buffer enables
//   en_bin      binary channel buffer enables
//   atb_sel     one-hot ATB mux select (all zero while bias is off)
//   ready       all permitted channels on and stable
//   busy        sequencer in SETTLE, RAMP or DOWN
module clkdist_seq_ctrl #(
    parameter int N_THERM = 17,
    parameter int N_BIN   = 7,
    parameter int SETTLE  = 8,
    parameter int STAGGER = 4
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic               pdb,
    input  logic [N_THERM-1:0] therm_mask,
    input  logic [N_BIN-1:0]   bin_mask,
    input  logic [1:0]         atb_ena,
    output logic               bias_en,
    output logic [N_THERM-1:0] en_therm,
    output logic [N_BIN-1:0]   en_bin,
    output logic [3:0]         atb_sel,
    output logic               ready,
    output logic               busy
);
    localparam int NT   = N_THERM + N_BIN;
    localparam int PW   = $clog2(NT + 1);
    localparam int TMAX = (SETTLE > STAGGER) ? SETTLE : STAGGER;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PTR_FULL    = PW'(NT);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] STEP_LAST   = TW'(STAGGER - 1);
    localparam logic [TW-1:0] TMR_SAT     = TW'(TMAX);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_RAMP   = 3'd2;
    localparam logic [2:0] S_ON     = 3'd3;
    localparam logic [2:0] S_DOWN   = 3'd4;

    logic              pdb_m_q, pdb_s_q;
    logic [2:0]        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     tmr_q, tmr_d, tmr_inc;

    logic               bias_en_d, ready_d, busy_d;
    logic [3:0]         atb_sel_d;
    logic [N_THERM-1:0] en_therm_d;
    logic [N_BIN-1:0]   en_bin_d;

    // Two-flop synchronizer for the asynchronous power-down-bar request.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            pdb_m_q <= 1'b0;
            pdb_s_q <= 1'b0;
        end else begin
            pdb_m_q <= pdb;
            pdb_s_q <= pdb_m_q;
        end
    end

    // One timer serves as both the settle timer and the step timer. The
    // states that use them are mutually exclusive, and the timer is cleared
    // on every state change. It saturates and never wraps.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        tmr_inc = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;
        case (state_q)
            S_OFF: begin
                if (pdb_s_q) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                end
            end
            S_SETTLE, S_RAMP, S_ON: begin
                if (!pdb_s_q) begin
                    // The first step down happens on the same edge the
                    // request is seen. With nothing enabled yet, go straight
                    // to OFF.
                    tmr_d = '0;
                    if (ptr_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = S_DOWN;
                        ptr_d   = ptr_q - 1'b1;
                    end
                end else if (state_q == S_SETTLE) begin
                    if (tmr_q >= SETTLE_LAST) begin
                        state_d = S_RAMP;
                        ptr_d   = PW'(1);
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end else if (state_q == S_RAMP) begin
                    if (tmr_q >= STEP_LAST) begin
                        tmr_d = '0;
                        if (ptr_q < PTR_FULL) ptr_d = ptr_q + 1'b1;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
                // Enter ON on the same edge the last position is enabled.
                if ((state_d == S_RAMP) && (ptr_d == PTR_FULL)) state_d = S_ON;
            end
            S_DOWN: begin
                if (pdb_s_q) begin
                    // Turn around from the current position. A full step
                    // interval passes before the next increment.
                    state_d = S_RAMP;
                    tmr_d   = '0;
                end else if (ptr_q == '0) begin
                    state_d = S_OFF;
                    tmr_d   = '0;
                end else if (tmr_q >= STEP_LAST) begin
                    ptr_d = ptr_q - 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: begin
                state_d = S_OFF;
                ptr_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state, so they change on the same edge
    // as the state and pointer. The masks only gate the enables. A masked
    // channel still takes up its step slot, so the ramp timing does not
    // depend on the masks.
    assign bias_en_d = (state_d != S_OFF);
    assign ready_d   = (state_d == S_ON);
    assign busy_d    = (state_d == S_SETTLE) || (state_d == S_RAMP) || (state_d == S_DOWN);
    assign atb_sel_d = bias_en_d ? (4'b0001 << atb_ena) : 4'b0000;

    for (genvar k = 0; k < N_THERM; k++) begin : g_therm
        localparam logic [PW-1:0] K = PW'(k);
        assign en_therm_d[k] = (K < ptr_d) && therm_mask[k];
    end

    for (genvar b = 0; b < N_BIN; b++) begin : g_bin
        localparam logic [PW-1:0] K = PW'(N_THERM + b);
        assign en_bin_d[b] = (K < ptr_d) && bin_mask[b];
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_OFF;
            ptr_q    <= '0;
            tmr_q    <= '0;
            bias_en  <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            atb_sel  <= 4'b0000;
            en_therm <= '0;
            en_bin   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tmr_q    <= tmr_d;
            bias_en  <= bias_en_d;
            ready    <= ready_d;
            busy     <= busy_d;
            atb_sel  <= atb_sel_d;
            en_therm <= en_therm_d;
            en_bin   <= en_bin_d;
        end
    end

endmodule

// File: tb/tb_clkdist_seq_ctrl.sv
// tb_clkdist_seq_ctrl
// Directed power-up/down scenarios with randomized masks, ATB codes and
// reversal points. The expected outputs for each edge come from closed-form
// arithmetic on the edge index, measured from the point where pdb is raised.
module tb_clkdist_seq_ctrl;
    localparam int N_THERM = 17;
    localparam int N_BIN   = 7;
    localparam int SETTLE  = 8;
    localparam int STAGGER = 4;
    localparam int NT      = N_THERM + N_BIN;
    // Edge at which the first channel turns on: 2 sync edges, 1 edge to
    // enter SETTLE, then SETTLE edges.
    localparam int T_RAMP  = 3 + SETTLE;

    logic               clkin = 1'b0;
    logic               rstb  = 1'b0;
    logic               pdb   = 1'b0;
    logic [N_THERM-1:0] therm_mask = '1;
    logic [N_BIN-1:0]   bin_mask   = '1;
    logic [1:0]         atb_ena    = 2'b00;
    logic               bias_en, ready, busy;
    logic [N_THERM-1:0] en_therm;
    logic [N_BIN-1:0]   en_bin;
    logic [3:0]         atb_sel;

    int checks   = 0;
    int failures = 0;

    // Scenario timing: e1 = edge at which ptr reaches p1 (pdb dropped right
    // after it), e2 = edge at which ptr is back down to p2 (pdb raised right
    // after it), e_ready = edge at which ready rises, e_off = edge after
    // which pdb is dropped from ON.
    int sc_rev, sc_p1, sc_p2, e1, e2, e_ready, e_off;

    clkdist_seq_ctrl #(
        .N_THERM (N_THERM),
        .N_BIN   (N_BIN),
        .SETTLE  (SETTLE),
        .STAGGER (STAGGER)
    ) dut (
        .clkin      (clkin),
        .rstb       (rstb),
        .pdb        (pdb),
        .therm_mask (therm_mask),
        .bin_mask   (bin_mask),
        .atb_ena    (atb_ena),
        .bias_en    (bias_en),
        .en_therm   (en_therm),
        .en_bin     (en_bin),
        .atb_sel    (atb_sel),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clkin = ~clkin;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " bias_en"},  64'(bias_en),  64'd0);
        chk({tag, " en_therm"}, 64'(en_therm), 64'd0);
        chk({tag, " en_bin"},   64'(en_bin),   64'd0);
        chk({tag, " atb_sel"},  64'(atb_sel),  64'd0);
        chk({tag, " ready"},    64'(ready),    64'd0);
        chk({tag, " busy"},     64'(busy),     64'd0);
    endtask

    // Count of enabled positions after edge e.
    function automatic int mdl_ptr(int e);
        int p;
        if (e >= e_off + 3) begin
            p = NT - 1 - (e - e_off - 3) / STAGGER;
            return (p < 0) ? 0 : p;
        end
        if (e < T_RAMP) return 0;
        if (sc_rev == 0 || e < e1 + 3) begin
            p = 1 + (e - T_RAMP) / STAGGER;
            return (p > NT) ? NT : p;
        end
        if (e < e2 + 3) return sc_p1 - 1 - (e - e1 - 3) / STAGGER;
        p = sc_p2 + (e - e2 - 3) / STAGGER;
        return (p > NT) ? NT : p;
    endfunction

    function automatic bit mdl_bias(int e);
        return (e >= 3) && (e <= e_off + 3 + (NT - 1) * STAGGER);
    endfunction

    function automatic bit mdl_ready(int e);
        return (e >= e_ready) && (e < e_off + 3);
    endfunction

    function automatic logic [N_THERM-1:0] exp_therm(int p, logic [N_THERM-1:0] m);
        logic [N_THERM-1:0] r;
        for (int k = 0; k < N_THERM; k++) r[k] = (k < p) && m[k];
        return r;
    endfunction

    function automatic logic [N_BIN-1:0] exp_bin(int p, logic [N_BIN-1:0] m);
        logic [N_BIN-1:0] r;
        for (int k = 0; k < N_BIN; k++) r[k] = ((N_THERM + k) < p) && m[k];
        return r;
    endfunction

    // Raise pdb from OFF (or hold it high across a reset release), optionally
    // reverse at p1 -> p2, hold ON for 'hold' edges, then power down to OFF.
    // A nonzero abort_e stops the run right after that edge.
    task automatic run_scenario(input string tag, input int rev, input int p1, input int p2,
                                input int hold, input int abort_e, input bit rand_mask);
        int p, end_e;
        bit b, r;
        logic [3:0] ea;
        sc_rev  = rev;
        sc_p1   = p1;
        sc_p2   = p2;
        e1      = T_RAMP + (p1 - 1) * STAGGER;
        e2      = e1 + 3 + (p1 - 1 - p2) * STAGGER;
        e_ready = (rev != 0) ? e2 + 3 + (NT - p2) * STAGGER : T_RAMP + (NT - 1) * STAGGER;
        e_off   = e_ready + hold;
        end_e   = (abort_e > 0) ? abort_e : e_off + 3 + (NT - 1) * STAGGER + 4;
        pdb = 1'b1;
        for (int e = 1; e <= end_e; e++) begin
            tick();
            p  = mdl_ptr(e);
            b  = mdl_bias(e);
            r  = mdl_ready(e);
            ea = b ? 4'(1 << atb_ena) : 4'd0;
            chk($sformatf("%s e=%0d bias_en", tag, e),  64'(bias_en),  64'(b));
            chk($sformatf("%s e=%0d ready", tag, e),    64'(ready),    64'(r));
            chk($sformatf("%s e=%0d busy", tag, e),     64'(busy),     64'(b && !r));
            chk($sformatf("%s e=%0d en_therm", tag, e), 64'(en_therm), 64'(exp_therm(p, therm_mask)));
            chk($sformatf("%s e=%0d en_bin", tag, e),   64'(en_bin),   64'(exp_bin(p, bin_mask)));
            chk($sformatf("%s e=%0d atb_sel", tag, e),  64'(atb_sel),  64'(ea));
            // Drive inputs for the next edge.
            if (rev != 0 && e == e1) pdb = 1'b0;
            if (rev != 0 && e == e2) pdb = 1'b1;
            if (e == e_off) pdb = 1'b0;
            atb_ena = 2'($urandom);
            if (rand_mask && $urandom_range(7, 0) == 0) begin
                therm_mask = N_THERM'($urandom);
                bin_mask   = N_BIN'($urandom);
            end
        end
    endtask

    initial begin
        int rp1, rp2;
        // Reset state.
        tick();
        tick();
        chk_all_zero("reset");
        rstb = 1'b1;

        // Idle in OFF with pdb low: ATB select stays zero for every code.
        for (int i = 0; i < 4; i++) begin
            atb_ena = 2'(i);
            tick();
            chk($sformatf("off_idle atb=%0d atb_sel", i), 64'(atb_sel), 64'd0);
            chk($sformatf("off_idle atb=%0d bias_en", i), 64'(bias_en), 64'd0);
        end

        // Full power-up / power-down, all channels allowed.
        run_scenario("pwrup_dn", 0, 0, 0, 5, 0, 1'b0);

        // Reversal 10 -> 6 and resume to full.
        run_scenario("reverse", 1, 10, 6, 3, 0, 1'b0);

        // Fixed masks: ramp timing is unchanged, only the enables are gated.
        therm_mask = N_THERM'(32'h00F0F);
        bin_mask   = N_BIN'(32'h55);
        run_scenario("masked", 0, 0, 0, 4, 0, 1'b0);

        // Random reversal point, hold time and masks changing mid-run.
        rp1 = $urandom_range(NT - 1, 2);
        rp2 = $urandom_range(rp1 - 1, 1);
        run_scenario($sformatf("rand_rev_%0d_%0d", rp1, rp2), 1, rp1, rp2,
                     $urandom_range(12, 1), 0, 1'b1);

        // Reset mid-ramp at ptr=12: enables drop at once, without a clock edge.
        therm_mask = '1;
        bin_mask   = '1;
        run_scenario("pre_rst", 0, 0, 0, 1, T_RAMP + 11 * STAGGER, 1'b0);
        #2;
        rstb = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        tick();
        chk_all_zero("rst_held");
        rstb = 1'b1;
        // pdb is still high, so the full sequence restarts from OFF.
        run_scenario("post_rst", 0, 0, 0, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkdist_seq_ctrl.md
CLKDIST_SEQ_CTRL -- requirements
Module: clkdist_seq_ctrl

Interface
REQ-001 Parameter: N_THERM, default 17, number of thermometer clock-buffer channels (1..32).
REQ-002 Parameter: N_BIN, default 7, number of binary clock-buffer channels including the redundant LSB (1..16).
REQ-003 Parameter: SETTLE, default 8, bias settle time in clkin cycles (>=1).
REQ-004 Parameter: STAGGER, default 4, clkin cycles between consecutive channel enable/disable steps (>=1).
REQ-005 Port: clkin  in  1  sole clock; all flops rising-edge.
REQ-006 Port: rstb  in  1  reset; asynchronous assert, active-low.
REQ-007 Port: pdb  in  1  power-down-bar request; asynchronous to clkin.
REQ-008 Port: therm_mask  in  N_THERM  per-channel allow (1 = may be enabled).
REQ-009 Port: bin_mask  in  N_BIN  per-channel allow.
REQ-010 Port: atb_ena  in  2  analog test bus selection code.
REQ-011 Port: bias_en  out  1  enables the 25 uA reference bias path.
REQ-012 Port: en_therm  out  N_THERM  thermometer channel buffer enables.
REQ-013 Port: en_bin  out  N_BIN  binary channel buffer enables.
REQ-014 Port: atb_sel  out  4  one-hot ATB mux select.
REQ-015 Port: ready  out  1  all permitted channels on and stable.
REQ-016 Port: busy  out  1  sequencer in a transitional state.

Function
REQ-017 pdb SHALL pass through a 2-flop synchronizer (pdb_s) reset to 0; all references below use pdb_s.
REQ-018 Channel order SHALL be a single index k = 0..NT-1, NT = N_THERM+N_BIN: therm 0..N_THERM-1 then bin 0..N_BIN-1.
REQ-019 A pointer ptr (0..NT) SHALL hold the count of enabled positions; position k enabled iff k < ptr.
REQ-020 All outputs SHALL be registered; en for position k = (k < ptr) AND mask bit, mask changes visible one edge later.
REQ-021 FSM states SHALL be OFF, SETTLE, RAMP, ON, DOWN; busy = 1 in SETTLE, RAMP, DOWN.
REQ-022 OFF, pdb_s=1: next edge -> SETTLE, bias_en=1, settle timer cleared.
REQ-023 SETTLE: after SETTLE edges in state -> RAMP, and ptr increments to 1 on that edge.
REQ-024 RAMP: ptr SHALL increment once every STAGGER edges; on the edge ptr reaches NT, state -> ON and ready=1.
REQ-025 ON: ptr = NT, ready = 1, bias_en = 1; held while pdb_s=1.
REQ-026 pdb_s=0 in SETTLE, RAMP or ON: next edge ready=0, state -> DOWN (or directly OFF with bias_en=0 if ptr=0), and ptr decrements on that edge.
REQ-027 DOWN: ptr SHALL decrement every STAGGER edges; one edge after ptr reaches 0, state -> OFF and bias_en=0.
REQ-028 pdb_s=1 in DOWN: state -> RAMP from current ptr, step timer restarted; next increment after STAGGER edges.
REQ-029 Masked-off channels SHALL still consume their STAGGER slot (timing independent of masks).
REQ-030 atb_sel SHALL equal one-hot(atb_ena) (00->0001 ... 11->1000) when bias_en=1, else 0000, updated one edge after input change.
REQ-031 Step timer and settle timer SHALL saturate/never wrap; ptr SHALL never exceed NT or go below 0.

Reset
REQ-032 rstb=0 SHALL asynchronously force: state OFF, ptr 0, pdb sync flops 0, bias_en 0, en_therm 0, en_bin 0, atb_sel 0000, ready 0, busy 0.
REQ-033 Reset mid-ramp SHALL drop all enables immediately (no ramp-down); after rstb release, behaviour restarts from OFF.

Verification
REQ-034 Defaults, masks all-1, pdb 0->1: bias_en rises 3 edges after pdb (2 sync + 1); en_therm[0] 8 edges later; en_bin[6] and ready after a further 23*4=92 edges.
REQ-035 From ON, pdb 1->0: ready falls 3 edges later, en_bin[6] clears same edge, en_therm[0] clears 92 edges after, bias_en clears 1 edge after that.
REQ-036 pdb low during RAMP at ptr=10, high again at ptr=6: ptr reverses 10->6, then resumes 6->24 at 4-edge spacing; ready only at 24.
REQ-037 therm_mask=0x00F0F, bin_mask=0x55: after ON, en_therm=0x00F0F, en_bin=0x55; ramp duration unchanged.
REQ-038 atb_ena swept 00,01,10,11 with bias_en=1 -> atb_sel 0001,0010,0100,1000; with pdb=0 in OFF -> 0000.
REQ-039 rstb pulsed low at ptr=12 in RAMP: all outputs 0 asynchronously; after release with pdb=1, full sequence repeats per REQ-034.
